maze_walker: RTL and testbench

MAZE_WALKER -- requirements
Module: maze_walker

---
 rtl/maze_walker_pkg.sv | 53 +++++
 rtl/maze_walker_if.sv | 22 ++
 rtl/maze_walker_dir_stack.sv | 49 ++++
 rtl/maze_walker.sv | 179 +++++++++++++++++
 tb/tb_maze_walker.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/maze_walker_pkg.sv
// Shared definitions for the maze walker: FSM state encoding, direction codes,
// goal cell, stack size, and the neighbour-stepping helpers.
// Latency: none (types and pure functions). Backpressure: none.
package maze_walker_pkg;

   typedef enum logic [3:0] {
      IDLE, MARK, TRY, RD, CHK, MOVE, NEXT, BACK, DONE, FAIL
   } state_t;

   typedef logic [1:0] dir_t;

   localparam dir_t DIR_RIGHT = 2'd0;   // x+1
   localparam dir_t DIR_DOWN  = 2'd1;   // y+1
   localparam dir_t DIR_LEFT  = 2'd2;   // x-1
   localparam dir_t DIR_UP    = 2'd3;   // y-1

   localparam logic [3:0] GOAL_X = 4'd15;
   localparam logic [3:0] GOAL_Y = 4'd15;

   localparam int STACK_DEPTH = 256;
   localparam int CNT_W       = 9;

   // Cell reached by one step from (x,y) in direction d, packed as {x, y}.
   // Wraps at the edges; callers use off_edge() to reject those steps.
   function automatic logic [7:0] step_cell(input logic [3:0] x, input logic [3:0] y,
                                            input dir_t d);
      logic [3:0] nx;
      logic [3:0] ny;
      nx = x;
      ny = y;
      case (d)
         DIR_RIGHT: nx = x + 4'd1;
         DIR_DOWN:  ny = y + 4'd1;
         DIR_LEFT:  nx = x - 4'd1;
         default:   ny = y - 4'd1;
      endcase
      return {nx, ny};
   endfunction

   // True when stepping from (x,y) in direction d leaves the 16x16 grid.
   function automatic logic off_edge(input logic [3:0] x, input logic [3:0] y,
                                     input dir_t d);
      logic r;
      case (d)
         DIR_RIGHT: r = (x == 4'd15);
         DIR_DOWN:  r = (y == 4'd15);
         DIR_LEFT:  r = (x == 4'd0);
         default:   r = (y == 4'd0);
      endcase
      return r;
   endfunction

endpackage

// File: rtl/maze_walker_if.sv
// Maze memory bus between the walker (master) and the cell memory (slave).
// Latency: read data returns one cycle after the mem_rd strobe. Backpressure: none.
// Signals: mem_rd/mem_wr strobes, x_pos/y_pos cell address, mem_data_in write data,
//          mem_data_out read data (0 = open, 1 = wall or visited).
interface maze_walker_if;
   logic       mem_rd;
   logic       mem_wr;
   logic [3:0] x_pos;
   logic [3:0] y_pos;
   logic       mem_data_in;
   logic       mem_data_out;

   modport master (
      output mem_rd, mem_wr, x_pos, y_pos, mem_data_in,
      input  mem_data_out
   );

   modport slave (
      input  mem_rd, mem_wr, x_pos, y_pos, mem_data_in,
      output mem_data_out
   );
endinterface

// File: rtl/maze_walker_dir_stack.sv
// LIFO of 2-bit directions recording the path taken by the walker.
// Latency: push/pop take effect on the next edge; dout shows the top entry combinationally.
// Backpressure: push ignored when full, pop ignored when empty.
// Ports: clk, rst (async, active-high), clr (sync empty), push/din, pop/dout,
//        empty, full, count (number of stored entries, 0..256).
module dir_stack
   import maze_walker_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  dir_t             din,
   output dir_t             dout,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] count
);

   dir_t       stk_mem [STACK_DEPTH];
   logic [7:0] top_idx;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(STACK_DEPTH));
   // count==256 wraps to index 255, so the top is addressable when full too.
   assign top_idx = count[7:0] - 8'd1;
   assign dout    = stk_mem[top_idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (push && !full) begin
         count <= count + CNT_W'(1);
      end else if (pop && !empty) begin
         count <= count - CNT_W'(1);
      end
   end

   // Storage needs no reset: entries above count are never read.
   always_ff @(posedge clk) begin
      if (push && !full && !clr) begin
         stk_mem[count[7:0]] <= din;
      end
   end

endmodule

// File: rtl/maze_walker.sv
// Depth-first maze search from (0,0) to (15,15) over a 16x16 one-bit cell memory.
// Latency: 5 cycles per forward step (MARK,TRY,RD,CHK,MOVE); memory reads return in 1 cycle.
// Backpressure: none; start is only honoured in IDLE and ignored while busy.
// Ports: clk, rst (async, active-high), start, mem (memory bus master),
//        busy, done/fail (sticky results), depth (stack depth = path length when done).
module maze_walker
   import maze_walker_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   maze_walker_if.master    mem,
   output logic             busy,
   output logic             done,
   output logic             fail,
   output logic [CNT_W-1:0] depth
);

   state_t     state;
   logic [3:0] cur_x;
   logic [3:0] cur_y;
   dir_t       dir;

   logic       rd_r;
   logic       wr_r;
   logic [3:0] addr_x;
   logic [3:0] addr_y;

   logic [3:0] nb_x;
   logic [3:0] nb_y;
   logic       nb_off;
   logic [3:0] bk_x;
   logic [3:0] bk_y;

   logic       stk_push;
   logic       stk_pop;
   logic       stk_clr;
   dir_t       stk_dout;
   logic       stk_empty;
   logic       stk_full;

   // Candidate neighbour for the direction under test.
   assign {nb_x, nb_y} = step_cell(cur_x, cur_y, dir);
   assign nb_off       = off_edge(cur_x, cur_y, dir);
   // Backtracking undoes the popped move: XOR with 2 gives the opposite direction.
   assign {bk_x, bk_y} = step_cell(cur_x, cur_y, dir_t'(stk_dout ^ 2'b10));

   assign stk_clr  = (state == IDLE) && start;
   assign stk_push = (state == MOVE) && !stk_full;
   assign stk_pop  = (state == BACK) && !stk_empty;

   dir_stack u_stack (
      .clk   (clk),
      .rst   (rst),
      .clr   (stk_clr),
      .push  (stk_push),
      .pop   (stk_pop),
      .din   (dir),
      .dout  (stk_dout),
      .empty (stk_empty),
      .full  (stk_full),
      .count (depth)
   );

   assign mem.mem_rd      = rd_r;
   assign mem.mem_wr      = wr_r;
   assign mem.x_pos       = addr_x;
   assign mem.y_pos       = addr_y;
   assign mem.mem_data_in = 1'b1;

   // Strobes and address are registered on entry to MARK/RD so each is high
   // for exactly the one cycle the FSM spends in that state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cur_x  <= '0;
         cur_y  <= '0;
         dir    <= DIR_RIGHT;
         rd_r   <= 1'b0;
         wr_r   <= 1'b0;
         addr_x <= '0;
         addr_y <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         fail   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state  <= MARK;
                  cur_x  <= '0;
                  cur_y  <= '0;
                  dir    <= DIR_RIGHT;
                  done   <= 1'b0;
                  fail   <= 1'b0;
                  busy   <= 1'b1;
                  wr_r   <= 1'b1;
                  addr_x <= '0;
                  addr_y <= '0;
               end
            end
            MARK: begin
               wr_r <= 1'b0;
               if (cur_x == GOAL_X && cur_y == GOAL_Y) begin
                  state <= DONE;
               end else begin
                  state <= TRY;
               end
            end
            TRY: begin
               if (nb_off) begin
                  state <= NEXT;
               end else begin
                  state  <= RD;
                  rd_r   <= 1'b1;
                  addr_x <= nb_x;
                  addr_y <= nb_y;
               end
            end
            RD: begin
               rd_r  <= 1'b0;
               state <= CHK;
            end
            CHK: begin
               if (mem.mem_data_out) begin
                  state <= NEXT;
               end else begin
                  state <= MOVE;
               end
            end
            MOVE: begin
               cur_x  <= nb_x;
               cur_y  <= nb_y;
               dir    <= DIR_RIGHT;
               state  <= MARK;
               wr_r   <= 1'b1;
               addr_x <= nb_x;
               addr_y <= nb_y;
            end
            NEXT: begin
               if (dir != DIR_UP) begin
                  dir   <= dir_t'(dir + 2'd1);
                  state <= TRY;
               end else begin
                  state <= BACK;
               end
            end
            BACK: begin
               if (stk_empty) begin
                  state <= FAIL;
               end else begin
                  cur_x <= bk_x;
                  cur_y <= bk_y;
                  // A popped UP means every direction at the parent is exhausted,
                  // so keep unwinding without revisiting TRY.
                  if (stk_dout != DIR_UP) begin
                     dir   <= dir_t'(stk_dout + 2'd1);
                     state <= TRY;
                  end
               end
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            FAIL: begin
               fail  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_maze_walker.sv
// Self-checking bench for maze_walker: table of maps with expected outcomes,
// plus hand sequences for mid-search reset, start-while-busy and sticky flags.
module tb_maze_walker;

   localparam int CYC_MAX = 20000;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       busy;
   logic       done;
   logic       fail;
   logic [8:0] depth;

   maze_walker_if mem();

   maze_walker dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .mem   (mem),
      .busy  (busy),
      .done  (done),
      .fail  (fail),
      .depth (depth)
   );

   always #5 clk = ~clk;

   // ---------------- maze memory model (1-cycle read latency) ----------------
   logic map [0:15][0:15];   // [y][x], 1 = wall or visited
   logic rd_q = 1'b0;
   assign mem.mem_data_out = rd_q;

   always @(posedge clk) begin
      if (mem.mem_rd) rd_q <= map[mem.y_pos][mem.x_pos];
      if (mem.mem_wr) map[mem.y_pos][mem.x_pos] = 1'b1;
   end

   // ---------------- monitor ----------------
   int         mon_err = 0;
   int         wr_cnt  = 0;
   int         rd_cnt  = 0;
   logic [3:0] last_wx = '0;
   logic [3:0] last_wy = '0;

   always @(negedge clk) begin
      if (!rst) begin
         if (mem.mem_rd && mem.mem_wr) begin
            mon_err++;
            $display("FAIL monitor rd_wr_overlap at %0t: rd=1 wr=1, required not both", $time);
         end
         if (mem.mem_wr) begin
            wr_cnt++;
            last_wx = mem.x_pos;
            last_wy = mem.y_pos;
            // A write to a closed cell means a revisit, a wall write, or a restart
            // from a start pulse taken while busy.
            if (map[mem.y_pos][mem.x_pos]) begin
               mon_err++;
               $display("FAIL monitor write_closed_cell at %0t: cell (%0d,%0d) already 1, required open",
                        $time, mem.x_pos, mem.y_pos);
            end
         end
         if (mem.mem_rd) rd_cnt++;
         if (dut.state == maze_walker_pkg::MOVE && dut.stk_full) begin
            mon_err++;
            $display("FAIL monitor push_full at %0t: push with full=1, required full=0", $time);
         end
      end
      if (mem.mem_data_in !== 1'b1) begin
         mon_err++;
         $display("FAIL monitor mem_data_in at %0t: got %b required 1", $time, mem.mem_data_in);
      end
   end

   // ---------------- checking helpers ----------------
   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   function automatic logic is_wall(input int id, input int x, input int y);
      case (id)
         1:       return (x == 1 && y == 0) || (x == 0 && y == 1);
         2:       return !(x == 0 || y == 15 || (x == 1 && y == 3) ||
                           (x == 2 && y == 3) || (x == 2 && y == 2));
         3:       return (x == 15 && y == 0);
         4:       return (x == 14 && y == 15) || (x == 15 && y == 14);
         default: return 1'b0;
      endcase
   endfunction

   // Expected stack entry k (bottom = 0) for maps that reach the goal.
   function automatic logic [31:0] exp_dir(input int id, input int k);
      case (id)
         2:       return (k < 15) ? 32'd1 : 32'd0;
         3:       return (k < 14) ? 32'd0 : (k == 14) ? 32'd1 : (k == 15) ? 32'd0 : 32'd1;
         default: return (k < 15) ? 32'd0 : 32'd1;
      endcase
   endfunction

   task automatic load_map(input int id);
      for (int y = 0; y < 16; y++)
         for (int x = 0; x < 16; x++)
            map[y][x] = is_wall(id, x, y);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < CYC_MAX) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic check_stack(input string tag, input int id, input int len);
      for (int k = 0; k < len; k++)
         check($sformatf("%s stack[%0d]", tag, k), 32'(dut.u_stack.stk_mem[k]), exp_dir(id, k));
   endtask

   typedef struct {
      int   map_id;
      logic exp_done;
      logic exp_fail;
      int   exp_depth;
      int   exp_wr;
      bit   chk_path;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int n;
      int w0;
      int r0;

      vecs[0] = '{0, 1'b1, 1'b0, 30,  31, 1'b1};  // all open: right then down
      vecs[1] = '{1, 1'b0, 1'b1,  0,   1, 1'b0};  // boxed in at origin
      vecs[2] = '{2, 1'b1, 1'b0, 30,  34, 1'b1};  // corridor with dead-end detour
      vecs[3] = '{3, 1'b1, 1'b0, 30,  31, 1'b1};  // (15,0) walled
      vecs[4] = '{4, 1'b0, 1'b1,  0, 253, 1'b0};  // goal sealed off, full sweep

      rst   = 1'b1;
      start = 1'b0;
      load_map(0);
      repeat (3) @(negedge clk);

      check("rst busy",   32'(busy),            0);
      check("rst done",   32'(done),            0);
      check("rst fail",   32'(fail),            0);
      check("rst depth",  32'(depth),           0);
      check("rst mem_rd", 32'(mem.mem_rd),      0);
      check("rst mem_wr", 32'(mem.mem_wr),      0);
      check("rst x_pos",  32'(mem.x_pos),       0);
      check("rst y_pos",  32'(mem.y_pos),       0);
      check("rst din",    32'(mem.mem_data_in), 1);

      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         string tag;
         tag = $sformatf("v%0d", i);
         load_map(vecs[i].map_id);
         w0 = wr_cnt;
         r0 = rd_cnt;
         pulse_start();
         check({tag, " flags_cleared"}, 32'({done, fail}), 0);
         check({tag, " busy"},          32'(busy),         1);
         wait_idle(n);
         check({tag, " timeout"}, 32'(n < CYC_MAX),   1);
         check({tag, " done"},    32'(done),          32'(vecs[i].exp_done));
         check({tag, " fail"},    32'(fail),          32'(vecs[i].exp_fail));
         check({tag, " depth"},   32'(depth),         vecs[i].exp_depth);
         check({tag, " writes"},  32'(wr_cnt - w0),   vecs[i].exp_wr);
         if (vecs[i].chk_path) check_stack(tag, vecs[i].map_id, vecs[i].exp_depth);
         if (vecs[i].map_id == 1) begin
            check({tag, " reads"},   32'(rd_cnt - r0),       2);
            check({tag, " wr_addr"}, 32'({last_wx, last_wy}), 0);
         end
      end

      // Results stay held while idle.
      repeat (5) @(negedge clk);
      check("sticky fail", 32'(fail), 1);
      check("sticky busy", 32'(busy), 0);

      // Reset 50 cycles into a search aborts at once and stays quiet.
      load_map(0);
      pulse_start();
      repeat (50) @(negedge clk);
      check("pre_rst busy", 32'(busy), 1);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("mid_rst busy",   32'(busy),       0);
      check("mid_rst mem_rd", 32'(mem.mem_rd), 0);
      check("mid_rst mem_wr", 32'(mem.mem_wr), 0);
      check("mid_rst depth",  32'(depth),      0);
      @(negedge clk);
      rst = 1'b0;
      w0 = wr_cnt;
      r0 = rd_cnt;
      repeat (20) @(negedge clk);
      check("post_rst quiet", 32'((wr_cnt - w0) + (rd_cnt - r0)), 0);
      check("post_rst busy",  32'(busy), 0);
      load_map(0);
      w0 = wr_cnt;
      pulse_start();
      wait_idle(n);
      check("rewalk timeout", 32'(n < CYC_MAX), 1);
      check("rewalk done",    32'(done),        1);
      check("rewalk depth",   32'(depth),       30);
      check("rewalk writes",  32'(wr_cnt - w0), 31);
      check_stack("rewalk", 0, 30);

      // Start pulses while busy must be ignored (a restart would rewrite (0,0)).
      load_map(2);
      w0 = wr_cnt;
      pulse_start();
      repeat (10) @(negedge clk);
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      wait_idle(n);
      check("busy_start timeout", 32'(n < CYC_MAX), 1);
      check("busy_start done",    32'(done),        1);
      check("busy_start depth",   32'(depth),       30);
      check("busy_start writes",  32'(wr_cnt - w0), 34);

      check("monitor errors", 32'(mon_err), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
